hazard_scoreboard: RTL and testbench

- Per-register write-pending scoreboard that schedules issue into the register-read stage.
- Decodes the incoming IR, compares its source registers against in-flight destination writes, and drives the read stage's `stall` input.
- Tracks outstanding writes with small per-register counters: incremented on issue, decremented on writeback.
- Sits beside the read stage; fed by the fetch IR/valid and by the writeback port.

---
 rtl/hazard_scoreboard_pkg.sv | 39 +++
 rtl/hazard_scoreboard_operand_decode.sv | 52 +++++
 rtl/hazard_scoreboard.sv | 125 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg
//   Shared definitions for the hazard scoreboard slice: RV32 major opcodes,
//   default counter width, operand-format enum and opcode classifier.
package hazard_scoreboard_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IM_ALU = 7'b0010011;
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;

  localparam int unsigned CNT_W_DEF = 2;

  // Which register fields an instruction format actually uses.
  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_RD,
    FMT_RS1_RD,
    FMT_RS1_RS2,
    FMT_RS1_RS2_RD
  } opnd_fmt_e;

  function automatic opnd_fmt_e classify(input logic [6:0] opcode);
    opnd_fmt_e f;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL:      f = FMT_RD;
      OP_JALR, OP_LOAD, OP_IM_ALU:   f = FMT_RS1_RD;
      OP_BRANCH, OP_STORE:           f = FMT_RS1_RS2;
      OP_ALU_R:                      f = FMT_RS1_RS2_RD;
      default:                       f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_operand_decode.sv
// operand_decode
//   Combinational decode of an instruction word into its register operands.
//   A field equal to x0 is reported as unused.
//   Ports:
//     IR          in  32  instruction word
//     o_uses_rs1  out 1   rs1 is a real source operand
//     o_uses_rs2  out 1   rs2 is a real source operand
//     o_uses_rd   out 1   rd is a real destination
//     o_rs1/o_rs2/o_rd out 5 register fields
module operand_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [31:0] IR,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2,
  output logic        o_uses_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd
);

  opnd_fmt_e w_fmt;
  logic      w_fmt_rs1;
  logic      w_fmt_rs2;
  logic      w_fmt_rd;
  logic      w_unused_ir;

  assign w_unused_ir = &{IR[31:25], IR[14:12]};

  assign o_rs1 = IR[19:15];
  assign o_rs2 = IR[24:20];
  assign o_rd  = IR[11:7];

  always_comb begin
    w_fmt     = classify(IR[6:0]);
    w_fmt_rs1 = 1'b0;
    w_fmt_rs2 = 1'b0;
    w_fmt_rd  = 1'b0;
    case (w_fmt)
      FMT_RD:         w_fmt_rd = 1'b1;
      FMT_RS1_RD:     begin w_fmt_rs1 = 1'b1; w_fmt_rd = 1'b1; end
      FMT_RS1_RS2:    begin w_fmt_rs1 = 1'b1; w_fmt_rs2 = 1'b1; end
      FMT_RS1_RS2_RD: begin w_fmt_rs1 = 1'b1; w_fmt_rs2 = 1'b1; w_fmt_rd = 1'b1; end
      default:        ;
    endcase
  end

  assign o_uses_rs1 = w_fmt_rs1 & (o_rs1 != 5'd0);
  assign o_uses_rs2 = w_fmt_rs2 & (o_rs2 != 5'd0);
  assign o_uses_rd  = w_fmt_rd  & (o_rd  != 5'd0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Per-register pending-write scoreboard driving the read-stage stall.
//   Counters increment on issue of an rd writer, decrement on writeback.
//   Optional macro WB_BYPASS_EN: a RAW on a register whose last pending
//   write is being written back this cycle does not stall (read-stage
//   bypass supplies the value).
//   Ports:
//     clk, rst       clock / async active-high reset
//     IR, v_in       instruction and valid from fetch
//     r_in           downstream ready
//     v_wb, WB_address writeback port
//     flush          discard all in-flight writes
//     stall, issue   combinational handshake outputs
//     busy           per-register nonzero-counter flags
//     sb_err         sticky underflow flag
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned NREG  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     IR,
  input  logic            v_in,
  input  logic            r_in,
  input  logic            v_wb,
  input  logic [4:0]      WB_address,
  input  logic            flush,
  output logic            stall,
  output logic            issue,
  output logic [NREG-1:0] busy,
  output logic            sb_err
);

  logic [CNT_W-1:0] r_cnt [1:NREG-1];
  logic             r_sb_err;

  logic             w_uses_rs1, w_uses_rs2, w_uses_rd;
  logic [4:0]       w_rs1, w_rs2, w_rd;

  logic [NREG-1:0]  w_nz, w_max, w_one, w_zero, w_inc, w_dec;
  logic [31:0]      w_nz_all, w_max_all, w_byp_all;
  logic             w_raw, w_struct;

  operand_decode u_dec (
    .IR         (IR),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_uses_rd  (w_uses_rd),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2),
    .o_rd       (w_rd)
  );

  // Per-register status vectors; x0 has no counter and reads as idle.
  always_comb begin
    w_nz   = '0;
    w_max  = '0;
    w_one  = '0;
    w_zero = '0;
    w_zero[0] = 1'b1;
    for (int unsigned i = 1; i < NREG; i++) begin
      w_nz[i]   = (r_cnt[i] != '0);
      w_max[i]  = (r_cnt[i] == '1);
      w_one[i]  = (r_cnt[i] == CNT_W'(1));
      w_zero[i] = (r_cnt[i] == '0);
    end
  end

  // Pad to the 5-bit register index space so field lookups stay in range.
  always_comb begin
    w_nz_all  = '0;
    w_max_all = '0;
    w_byp_all = '0;
    w_nz_all[NREG-1:0]  = w_nz;
    w_max_all[NREG-1:0] = w_max;
`ifdef WB_BYPASS_EN
    if (v_wb && (WB_address != 5'd0) && w_one[WB_address])
      w_byp_all[WB_address] = 1'b1;
`endif
  end

  assign w_raw    = (w_uses_rs1 & w_nz_all[w_rs1] & ~w_byp_all[w_rs1]) |
                    (w_uses_rs2 & w_nz_all[w_rs2] & ~w_byp_all[w_rs2]);
  assign w_struct = w_uses_rd & w_max_all[w_rd];

  assign stall = v_in & ~flush & (w_raw | w_struct);
  assign issue = v_in & r_in & ~stall & ~flush;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      w_inc[i] = issue & w_uses_rd & (w_rd == 5'(i));
      w_dec[i] = v_wb & (WB_address == 5'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREG; i++) r_cnt[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 1; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (w_dec[i] && !w_inc[i] && !w_zero[i])
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_sb_err <= 1'b0;
    else if (!flush && |(w_dec & w_zero))
      r_sb_err <= 1'b1;
  end

  assign busy   = w_nz;
  assign sb_err = r_sb_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam logic [31:0] I_IDLE     = 32'h0000_0000;
  localparam logic [31:0] I_ADDI_X5  = 32'h0010_0293;
  localparam logic [31:0] I_ADDI_X6  = 32'h0010_0313;
  localparam logic [31:0] I_ADDI_X7  = 32'h0010_0393;
  localparam logic [31:0] I_ADDI_X8  = 32'h0010_0413;
  localparam logic [31:0] I_ADDI_X0  = 32'h0010_0013;
  localparam logic [31:0] I_ADD_655  = 32'h0052_8333;
  localparam logic [31:0] I_ADD_600  = 32'h0000_0333;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR;
  logic        v_in, r_in, v_wb, flush;
  logic [4:0]  WB_address;
  logic        stall, issue, sb_err;
  logic [31:0] busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] ir;
    logic        vin, rin, vwb;
    logic [4:0]  wba;
    logic        fl;
    logic        es, ei;
    logic [31:0] eb;
    logic        ee;
  } step_t;

  typedef struct {
    string       nm;
    logic        es, ei;
    logic [31:0] eb;
    logic        ee;
  } exp_t;

  exp_t exp_q[$];

  hazard_scoreboard #(.CNT_W(2), .NREG(32)) dut (
    .clk(clk), .rst(rst), .IR(IR), .v_in(v_in), .r_in(r_in),
    .v_wb(v_wb), .WB_address(WB_address), .flush(flush),
    .stall(stall), .issue(issue), .busy(busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(logic [31:0] ir, logic vin, logic rin, logic vwb,
                               logic [4:0] wba, logic fl, logic es, logic ei,
                               logic [31:0] eb, logic ee);
    step_t s;
    s.ir = ir; s.vin = vin; s.rin = rin; s.vwb = vwb; s.wba = wba; s.fl = fl;
    s.es = es; s.ei = ei; s.eb = eb; s.ee = ee;
    return s;
  endfunction

  // Drive one cycle of stimulus between edges and queue what it must produce.
  task automatic apply(input string nm, input step_t s);
    exp_t e;
    @(negedge clk);
    IR = s.ir; v_in = s.vin; r_in = s.rin; v_wb = s.vwb;
    WB_address = s.wba; flush = s.fl;
    e.nm = nm; e.es = s.es; e.ei = s.ei; e.eb = s.eb; e.ee = s.ee;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; IR = I_IDLE; v_in = 1'b0; r_in = 1'b1; v_wb = 1'b0;
    WB_address = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 32'h0 || sb_err !== 1'b0 || stall !== 1'b0 || issue !== 1'b0) begin
      bad++;
      $display("FAIL reset: busy=%h sb_err=%b stall=%b issue=%b, required 0/0/0/0",
               busy, sb_err, stall, issue);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    exp_t  e;
    t.push_back(mk(I_ADDI_X5, 1, 1, 0, 0, 0, 0, 1, 32'h0, 0));
    t.push_back(mk(I_ADD_655, 1, 1, 0, 0, 0, 1, 0, 32'h20, 0));
`ifdef WB_BYPASS_EN
    t.push_back(mk(I_ADD_655, 1, 1, 1, 5, 0, 0, 1, 32'h20, 0));
    t.push_back(mk(I_IDLE,    0, 1, 0, 0, 0, 0, 0, 32'h40, 0));
`else
    t.push_back(mk(I_ADD_655, 1, 1, 1, 5, 0, 1, 0, 32'h20, 0));
    t.push_back(mk(I_ADD_655, 1, 1, 0, 0, 0, 0, 1, 32'h0, 0));
`endif
    t.push_back(mk(I_IDLE, 0, 1, 1, 6, 0, 0, 0, 32'h40, 0));
    t.push_back(mk(I_IDLE, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0));
    foreach (t[k]) begin
      apply($sformatf("b2b[%0d]", k), t[k]);
      #1;
      e = exp_q.pop_front();
      total++;
      if (stall !== e.es || issue !== e.ei || busy !== e.eb || sb_err !== e.ee) begin
        bad++;
        $display("FAIL %s: stall=%b issue=%b busy=%h err=%b, required %b %b %h %b",
                 e.nm, stall, issue, busy, sb_err, e.es, e.ei, e.eb, e.ee);
      end
    end
  endtask

  task automatic test_x0();
    step_t t[$];
    exp_t  e;
    t.push_back(mk(I_ADDI_X0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    t.push_back(mk(I_ADDI_X0, 1, 1, 0, 0, 0, 0, 1, 32'h0, 0));
    t.push_back(mk(I_ADD_600, 1, 1, 0, 0, 0, 0, 1, 32'h0, 0));
    t.push_back(mk(I_ADD_600, 1, 0, 1, 0, 0, 0, 0, 32'h40, 0));
    t.push_back(mk(I_IDLE,    0, 1, 1, 6, 0, 0, 0, 32'h40, 0));
    t.push_back(mk(I_IDLE,    0, 1, 0, 0, 0, 0, 0, 32'h0, 0));
    foreach (t[k]) begin
      apply($sformatf("x0[%0d]", k), t[k]);
      #1;
      e = exp_q.pop_front();
      total++;
      if (stall !== e.es || issue !== e.ei || busy !== e.eb || sb_err !== e.ee) begin
        bad++;
        $display("FAIL %s: stall=%b issue=%b busy=%h err=%b, required %b %b %h %b",
                 e.nm, stall, issue, busy, sb_err, e.es, e.ei, e.eb, e.ee);
      end
    end
  endtask

  task automatic test_saturation();
    step_t t[$];
    exp_t  e;
    t.push_back(mk(I_ADDI_X7, 1, 1, 0, 0, 0, 0, 1, 32'h0, 0));
    t.push_back(mk(I_ADDI_X7, 1, 1, 0, 0, 0, 0, 1, 32'h80, 0));
    t.push_back(mk(I_ADDI_X7, 1, 1, 0, 0, 0, 0, 1, 32'h80, 0));
    t.push_back(mk(I_ADDI_X7, 1, 1, 0, 0, 0, 1, 0, 32'h80, 0));
    t.push_back(mk(I_ADDI_X7, 1, 1, 1, 7, 0, 1, 0, 32'h80, 0));
    t.push_back(mk(I_ADDI_X7, 1, 1, 0, 0, 0, 0, 1, 32'h80, 0));
    t.push_back(mk(I_ADDI_X7, 1, 1, 0, 0, 0, 1, 0, 32'h80, 0));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(I_IDLE, 0, 1, 1, 7, 0, 0, 0, 32'h80, 0));
    t.push_back(mk(I_IDLE, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0));
    foreach (t[k]) begin
      apply($sformatf("sat[%0d]", k), t[k]);
      #1;
      e = exp_q.pop_front();
      total++;
      if (stall !== e.es || issue !== e.ei || busy !== e.eb || sb_err !== e.ee) begin
        bad++;
        $display("FAIL %s: stall=%b issue=%b busy=%h err=%b, required %b %b %h %b",
                 e.nm, stall, issue, busy, sb_err, e.es, e.ei, e.eb, e.ee);
      end
    end
  endtask

  task automatic test_simul_inc_dec();
    step_t t[$];
    exp_t  e;
    t.push_back(mk(I_ADDI_X8, 1, 1, 0, 0, 0, 0, 1, 32'h0, 0));
    t.push_back(mk(I_ADDI_X8, 1, 1, 1, 8, 0, 0, 1, 32'h100, 0));
    t.push_back(mk(I_IDLE,    0, 1, 0, 0, 0, 0, 0, 32'h100, 0));
    t.push_back(mk(I_IDLE,    0, 1, 1, 8, 0, 0, 0, 32'h100, 0));
    t.push_back(mk(I_IDLE,    0, 1, 0, 0, 0, 0, 0, 32'h0, 0));
    foreach (t[k]) begin
      apply($sformatf("incdec[%0d]", k), t[k]);
      #1;
      e = exp_q.pop_front();
      total++;
      if (stall !== e.es || issue !== e.ei || busy !== e.eb || sb_err !== e.ee) begin
        bad++;
        $display("FAIL %s: stall=%b issue=%b busy=%h err=%b, required %b %b %h %b",
                 e.nm, stall, issue, busy, sb_err, e.es, e.ei, e.eb, e.ee);
      end
    end
  endtask

  task automatic test_flush_err();
    step_t t[$];
    exp_t  e;
    t.push_back(mk(I_ADDI_X5, 1, 1, 0, 0, 0, 0, 1, 32'h0, 0));
    t.push_back(mk(I_ADDI_X6, 1, 1, 0, 0, 0, 0, 1, 32'h20, 0));
    t.push_back(mk(I_ADDI_X7, 1, 1, 0, 0, 0, 0, 1, 32'h60, 0));
    t.push_back(mk(I_IDLE,    0, 1, 0, 0, 0, 0, 0, 32'hE0, 0));
    t.push_back(mk(I_ADD_655, 1, 1, 1, 5, 1, 0, 0, 32'hE0, 0));
    t.push_back(mk(I_IDLE,    0, 1, 1, 3, 0, 0, 0, 32'h0, 0));
    t.push_back(mk(I_IDLE,    0, 1, 0, 0, 0, 0, 0, 32'h0, 1));
    t.push_back(mk(I_ADDI_X5, 1, 1, 0, 0, 0, 0, 1, 32'h0, 1));
    t.push_back(mk(I_IDLE,    0, 1, 0, 0, 0, 0, 0, 32'h20, 1));
    foreach (t[k]) begin
      apply($sformatf("flush[%0d]", k), t[k]);
      #1;
      e = exp_q.pop_front();
      total++;
      if (stall !== e.es || issue !== e.ei || busy !== e.eb || sb_err !== e.ee) begin
        bad++;
        $display("FAIL %s: stall=%b issue=%b busy=%h err=%b, required %b %b %h %b",
                 e.nm, stall, issue, busy, sb_err, e.es, e.ei, e.eb, e.ee);
      end
    end
    // Async reset between edges must clear state without a clock.
    #1 rst = 1'b1;
    #1;
    total++;
    if (busy !== 32'h0 || sb_err !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: busy=%h sb_err=%b, required 0 0", busy, sb_err);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (busy !== 32'h0 || sb_err !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL post_rst: busy=%h sb_err=%b stall=%b, required 0 0 0",
               busy, sb_err, stall);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_x0();
    test_saturation();
    test_simul_inc_dec();
    test_flush_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
